// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta DAC: each accepted code plays for OSR modulator cycles as a
// 1-bit pulse-density stream, with a one-entry holding buffer for gapless playback.
module sigma_delta_dac #(
  parameter int WIDTH = 8,
  parameter int OSR   = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_in,
  output logic             sample_ready,
  output logic             dac_out,
  output logic             busy,
  output logic             sample_done
);

  localparam int CNT_W = (OSR > 2) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dac_q, dac_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic             accept;
  logic             last;

  assign sample_ready = !pend_full_q;
  assign accept       = sample_valid && !pend_full_q;
  assign last         = (cnt_q == CNT_LAST);
  assign sum          = {1'b0, acc_q} + {1'b0, cur_q};

  assign dac_out     = dac_q;
  assign busy        = busy_q;
  assign sample_done = done_q;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dac_d       = dac_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        dac_d  = 1'b0;
        acc_d  = '0;
        busy_d = 1'b0;
        if (accept) begin
          cur_d   = sample_in;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        dac_d = sum[WIDTH];
        acc_d = sum[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (!last) begin
          if (accept) begin
            pend_d      = sample_in;
            pend_full_d = 1'b1;
          end
        end else begin
          // Window boundary: acc carries over so back-to-back windows stay exact.
          done_d = 1'b1;
          cnt_d  = '0;
          if (pend_full_q) begin
            cur_d       = pend_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            cur_d = sample_in;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            acc_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dac_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dac_q       <= dac_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Directed bench for sigma_delta_dac: counts ones per window between sample_done pulses
// and compares against hand-computed codes, handshake timing and reset behaviour.
module tb_sigma_delta_dac;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [7:0] sample_in;
  logic       sample_ready;
  logic       dac_out;
  logic       busy;
  logic       sample_done;

  int checks;
  int failures;

  int ones;
  int bit_idx;
  int done_cnt;
  int busy_run;
  int last_busy_run;
  bit prev_busy;
  bit cur_bits[256];
  bit last_bits[256];
  int win_q[$];

  sigma_delta_dac #(.WIDTH(8), .OSR(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sample_ready (sample_ready),
    .dac_out      (dac_out),
    .busy         (busy),
    .sample_done  (sample_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window monitor: a bit belongs to a window when busy was high at the previous sample.
  always @(negedge clk) begin
    if (!rst) begin
      ones      = 0;
      bit_idx   = 0;
      busy_run  = 0;
      prev_busy = 1'b0;
    end else begin
      if (prev_busy) begin
        ones = ones + int'(dac_out);
        if (bit_idx < 256) cur_bits[bit_idx] = dac_out;
        bit_idx = bit_idx + 1;
      end
      if (sample_done) begin
        win_q.push_back(ones);
        last_bits = cur_bits;
        ones      = 0;
        bit_idx   = 0;
        done_cnt  = done_cnt + 1;
      end
      if (busy) busy_run = busy_run + 1;
      else if (busy_run != 0) begin
        last_busy_run = busy_run;
        busy_run      = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] code);
    sample_valid = 1'b1;
    sample_in    = code;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    check_eq(tag, done_cnt, target);
  endtask

  task automatic check_win(input string tag, input int exp);
    if (win_q.size() == 0) check_eq(tag, -1, exp);
    else check_eq(tag, win_q.pop_front(), exp);
  endtask

  initial begin
    int d0;
    int lowcnt;
    checks        = 0;
    failures      = 0;
    done_cnt      = 0;
    last_busy_run = 0;
    rst           = 1'b0;
    sample_valid  = 1'b0;
    sample_in     = 8'd0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_dac", int'(dac_out), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(sample_done), 0);
    rst = 1'b1;
    tick();
    check_eq("rst_ready", int'(sample_ready), 1);

    // Code 0: silent 256-cycle window
    d0 = done_cnt;
    start(8'd0);
    check_eq("c0_busy", int'(busy), 1);
    wait_done("c0_done", d0 + 1);
    tick();
    tick();
    check_win("c0_ones", 0);
    check_eq("c0_busy_run", last_busy_run, 256);
    check_eq("c0_idle_dac", int'(dac_out), 0);
    check_eq("c0_idle_busy", int'(busy), 0);
    check_eq("c0_idle_ready", int'(sample_ready), 1);

    // Code 255: first bit 0, every later bit 1
    d0 = done_cnt;
    start(8'd255);
    wait_done("c255_done", d0 + 1);
    tick();
    check_win("c255_ones", 255);
    check_eq("c255_bit0", int'(last_bits[0]), 0);
    check_eq("c255_bit1", int'(last_bits[1]), 1);
    check_eq("c255_bit255", int'(last_bits[255]), 1);

    // Code 128: alternating 0,1,0,1
    d0 = done_cnt;
    start(8'd128);
    wait_done("c128_done", d0 + 1);
    tick();
    check_win("c128_ones", 128);
    check_eq("c128_bit0", int'(last_bits[0]), 0);
    check_eq("c128_bit1", int'(last_bits[1]), 1);
    check_eq("c128_bit2", int'(last_bits[2]), 0);
    check_eq("c128_bit255", int'(last_bits[255]), 1);

    // Back-to-back 64 / 192 / 37 with continuous valid
    tick();
    d0 = done_cnt;
    sample_valid = 1'b1;
    sample_in    = 8'd64;
    tick();
    sample_in = 8'd192;
    tick();
    sample_in = 8'd37;
    check_eq("b2b_ready_low", int'(sample_ready), 0);
    lowcnt = 0;
    while (!sample_ready && lowcnt < 600) begin
      lowcnt++;
      tick();
    end
    check_eq("b2b_ready_low_cycles", lowcnt, 255);
    tick();
    sample_valid = 1'b0;
    check_eq("b2b_pend37_ready", int'(sample_ready), 0);
    wait_done("b2b_done3", d0 + 3);
    tick();
    tick();
    check_win("b2b_ones64", 64);
    check_win("b2b_ones192", 192);
    check_win("b2b_ones37", 37);
    check_eq("b2b_busy_run", last_busy_run, 768);

    // Reset mid-window with a pending sample
    d0 = done_cnt;
    start(8'd100);
    sample_valid = 1'b1;
    sample_in    = 8'd55;
    tick();
    sample_valid = 1'b0;
    check_eq("rmw_pend_ready", int'(sample_ready), 0);
    repeat (48) tick();
    rst = 1'b0;
    tick();
    check_eq("rmw_dac", int'(dac_out), 0);
    check_eq("rmw_busy", int'(busy), 0);
    tick();
    rst = 1'b1;
    tick();
    check_eq("rmw_ready", int'(sample_ready), 1);
    repeat (5) tick();
    check_eq("rmw_no_restart", int'(busy), 0);
    check_eq("rmw_no_done", done_cnt, d0);
    start(8'd101);
    wait_done("rmw_done101", d0 + 1);
    tick();
    check_win("rmw_ones101", 101);

    // Held valid while pend full: stale 200 must not be captured, 7 is
    tick();
    d0 = done_cnt;
    start(8'd10);
    sample_valid = 1'b1;
    sample_in    = 8'd99;
    tick();
    sample_in = 8'd200;
    tick();
    check_eq("hold_ready_low", int'(sample_ready), 0);
    repeat (20) tick();
    sample_in = 8'd7;
    lowcnt = 0;
    while (!sample_ready && lowcnt < 600) begin
      lowcnt++;
      tick();
    end
    tick();
    sample_valid = 1'b0;
    sample_in    = 8'd250;
    wait_done("hold_done3", d0 + 3);
    tick();
    check_win("hold_ones10", 10);
    check_win("hold_ones99", 99);
    check_win("hold_ones7", 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
